// File: rtl/jtag_tap_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_tap_slave: IEEE 1149.1 TAP slave oversampled on clk, with IDCODE,     |
// | user data and bypass data registers.                                      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module jtag_tap_slave #(
  parameter int                       INSTR_LENGTH = 5,
  parameter int                       DATA_LENGTH  = 256,
  parameter logic [31:0]              IDCODE_VAL   = 32'h1000_0B5D,
  parameter logic [INSTR_LENGTH-1:0]  IDCODE_INST  = 5'h11,
  parameter logic [INSTR_LENGTH-1:0]  DATA_INST    = 5'h12,
  parameter logic [INSTR_LENGTH-1:0]  BYPASS_INST  = 5'h1F
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tck,
  input  logic                    tms,
  input  logic                    tdi,
  output logic                    tdo,
  output logic                    tdo_en,
  input  logic [DATA_LENGTH-1:0]  data_in,
  output logic [DATA_LENGTH-1:0]  data_out,
  output logic                    data_update,
  output logic [INSTR_LENGTH-1:0] ir_out,
  output logic [3:0]              tap_state
);

  typedef enum logic [3:0] {
    S_TLR     = 4'hF,
    S_RTI     = 4'hC,
    S_SEL_DR  = 4'h7,
    S_CAP_DR  = 4'h6,
    S_SH_DR   = 4'h2,
    S_EX1_DR  = 4'h1,
    S_PAU_DR  = 4'h3,
    S_EX2_DR  = 4'h0,
    S_UPD_DR  = 4'h5,
    S_SEL_IR  = 4'h4,
    S_CAP_IR  = 4'hE,
    S_SH_IR   = 4'hA,
    S_EX1_IR  = 4'h9,
    S_PAU_IR  = 4'hB,
    S_EX2_IR  = 4'h8,
    S_UPD_IR  = 4'hD
  } tap_state_t;

  localparam logic [INSTR_LENGTH-1:0] c_ir_capture = INSTR_LENGTH'(1);

  tap_state_t r_state;
  tap_state_t w_state_nxt;

  logic [1:0] r_tck_sync;
  logic [1:0] r_tms_sync;
  logic [1:0] r_tdi_sync;
  logic       r_tck_prev;

  logic w_tck_rise;
  logic w_tck_fall;
  logic w_tms;
  logic w_tdi;

  logic [INSTR_LENGTH-1:0] r_ir_sr;
  logic [INSTR_LENGTH-1:0] r_ir;
  logic [31:0]             r_id_sr;
  logic [DATA_LENGTH-1:0]  r_data_sr;
  logic                    r_byp_sr;
  logic [DATA_LENGTH-1:0]  r_data_out;
  logic                    r_data_update;
  logic                    r_tdo;
  logic                    r_tdo_en;

  logic w_sel_id;
  logic w_sel_data;
  logic w_sel_byp;
  logic w_dr_lsb;

  // Pin synchronizers; edges are seen as a change of the synchronized tck.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tck_sync <= 2'b00;
      r_tms_sync <= 2'b00;
      r_tdi_sync <= 2'b00;
      r_tck_prev <= 1'b0;
    end else begin
      r_tck_sync <= {r_tck_sync[0], tck};
      r_tms_sync <= {r_tms_sync[0], tms};
      r_tdi_sync <= {r_tdi_sync[0], tdi};
      r_tck_prev <= r_tck_sync[1];
    end
  end

  assign w_tck_rise = r_tck_sync[1] & ~r_tck_prev;
  assign w_tck_fall = ~r_tck_sync[1] & r_tck_prev;
  assign w_tms      = r_tms_sync[1];
  assign w_tdi      = r_tdi_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_TLR;
    end else if (w_tck_rise) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_TLR:    w_state_nxt = w_tms ? S_TLR    : S_RTI;
      S_RTI:    w_state_nxt = w_tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: w_state_nxt = w_tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: w_state_nxt = w_tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  w_state_nxt = w_tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: w_state_nxt = w_tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: w_state_nxt = w_tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: w_state_nxt = w_tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: w_state_nxt = w_tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: w_state_nxt = w_tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: w_state_nxt = w_tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  w_state_nxt = w_tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: w_state_nxt = w_tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: w_state_nxt = w_tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: w_state_nxt = w_tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: w_state_nxt = w_tms ? S_SEL_DR : S_RTI;
      default:  w_state_nxt = S_TLR;
    endcase
  end

  // Unknown instructions fall back to bypass, as does the explicit code.
  assign w_sel_id   = (r_ir == IDCODE_INST);
  assign w_sel_data = (r_ir == DATA_INST);
  assign w_sel_byp  = (r_ir == BYPASS_INST) || !(w_sel_id || w_sel_data);

  always_comb begin
    w_dr_lsb = r_byp_sr;
    if (w_sel_id) begin
      w_dr_lsb = r_id_sr[0];
    end else if (w_sel_data) begin
      w_dr_lsb = r_data_sr[0];
    end
  end

  // Actions are keyed on the state held before the tck rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir_sr       <= '0;
      r_ir          <= IDCODE_INST;
      r_id_sr       <= '0;
      r_data_sr     <= '0;
      r_byp_sr      <= 1'b0;
      r_data_out    <= '0;
      r_data_update <= 1'b0;
    end else begin
      r_data_update <= 1'b0;
      if (w_tck_rise) begin
        case (r_state)
          S_CAP_IR: r_ir_sr <= c_ir_capture;
          S_SH_IR:  r_ir_sr <= {w_tdi, r_ir_sr[INSTR_LENGTH-1:1]};
          S_UPD_IR: r_ir    <= r_ir_sr;
          S_CAP_DR: begin
            if (w_sel_id) begin
              r_id_sr <= IDCODE_VAL;
            end else if (w_sel_data) begin
              r_data_sr <= data_in;
            end else if (w_sel_byp) begin
              r_byp_sr <= 1'b0;
            end
          end
          S_SH_DR: begin
            if (w_sel_id) begin
              r_id_sr <= {w_tdi, r_id_sr[31:1]};
            end else if (w_sel_data) begin
              r_data_sr <= {w_tdi, r_data_sr[DATA_LENGTH-1:1]};
            end else if (w_sel_byp) begin
              r_byp_sr <= w_tdi;
            end
          end
          S_UPD_DR: begin
            if (w_sel_data) begin
              r_data_out    <= r_data_sr;
              r_data_update <= 1'b1;
            end
          end
          default: ;
        endcase
        if (w_state_nxt == S_TLR) begin
          r_ir <= IDCODE_INST;
        end
      end
    end
  end

  // tdo changes on the falling edge so the master sees it stable at rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else if (w_tck_fall) begin
      if (r_state == S_SH_IR) begin
        r_tdo <= r_ir_sr[0];
      end else if (r_state == S_SH_DR) begin
        r_tdo <= w_dr_lsb;
      end
      r_tdo_en <= (r_state == S_SH_IR) || (r_state == S_SH_DR);
    end
  end

  assign tdo         = r_tdo;
  assign tdo_en      = r_tdo_en;
  assign data_out    = r_data_out;
  assign data_update = r_data_update;
  assign ir_out      = r_ir;
  assign tap_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jtag_tap_slave: table-driven state walk plus scoreboarded scans.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_jtag_tap_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic         tck;
  logic         tms;
  logic         tdi;
  logic         tdo;
  logic         tdo_en;
  logic [255:0] data_in;
  logic [255:0] data_out;
  logic         data_update;
  logic [4:0]   ir_out;
  logic [3:0]   tap_state;

  jtag_tap_slave dut (
    .clk         (clk),
    .rst         (rst),
    .tck         (tck),
    .tms         (tms),
    .tdi         (tdi),
    .tdo         (tdo),
    .tdo_en      (tdo_en),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_update (data_update),
    .ir_out      (ir_out),
    .tap_state   (tap_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tms;
    logic [3:0] st;
    logic       en;
  } vec_t;

  vec_t         tbl [24];
  int           total = 0;
  int           bad = 0;
  int           upd_cnt = 0;
  logic [511:0] tdi_bits;
  int           vidx;
  logic [255:0] mdl;
  int           mdl_len;
  logic         exp_q [$];
  logic [255:0] exp_dout;
  logic         s;

  always @(negedge clk) begin
    if (data_update) upd_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tck_cycle(input logic m, input logic d, output logic smp);
    tms = m;
    tdi = d;
    repeat (4) @(posedge clk);
    #1;
    smp = tdo;
    tck = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tck = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reference register: bit 0 leaves first, tdi enters at the top.
  task automatic shift_bits(input int n, input logic exit_last);
    logic smp;
    logic d;
    for (int i = 0; i < n; i++) begin
      d = tdi_bits[vidx];
      vidx++;
      exp_q.push_back(mdl[0]);
      mdl = mdl >> 1;
      mdl[mdl_len-1] = d;
      tck_cycle(exit_last && (i == n - 1), d, smp);
      check("tdo", {255'b0, smp}, {255'b0, exp_q.pop_front()});
    end
  endtask

  task automatic goto_shdr();
    tck_cycle(1'b1, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
  endtask

  task automatic finish_upd();
    tck_cycle(1'b1, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
  endtask

  task automatic load_ir(input logic [4:0] code);
    tck_cycle(1'b1, 1'b0, s);
    tck_cycle(1'b1, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
    tck_cycle(1'b0, 1'b0, s);
    mdl = 256'd1;
    mdl_len = 5;
    tdi_bits = {507'b0, code};
    vidx = 0;
    shift_bits(5, 1'b1);
    finish_upd();
    check("ir_out", {251'b0, ir_out}, {251'b0, code});
  endtask

  task automatic scan_dr(input logic [255:0] cap, input int len, input int n);
    goto_shdr();
    mdl = cap;
    mdl_len = len;
    vidx = 0;
    shift_bits(n, 1'b1);
    finish_upd();
  endtask

  initial begin
    tbl = '{
      '{1'b0, 4'hC, 1'b0}, '{1'b1, 4'h7, 1'b0}, '{1'b0, 4'h6, 1'b0}, '{1'b0, 4'h2, 1'b1},
      '{1'b1, 4'h1, 1'b0}, '{1'b0, 4'h3, 1'b0}, '{1'b1, 4'h0, 1'b0}, '{1'b0, 4'h2, 1'b1},
      '{1'b1, 4'h1, 1'b0}, '{1'b1, 4'h5, 1'b0}, '{1'b1, 4'h7, 1'b0}, '{1'b1, 4'h4, 1'b0},
      '{1'b0, 4'hE, 1'b0}, '{1'b0, 4'hA, 1'b1}, '{1'b1, 4'h9, 1'b0}, '{1'b0, 4'hB, 1'b0},
      '{1'b1, 4'h8, 1'b0}, '{1'b0, 4'hA, 1'b1}, '{1'b1, 4'h9, 1'b0}, '{1'b1, 4'hD, 1'b0},
      '{1'b0, 4'hC, 1'b0}, '{1'b1, 4'h7, 1'b0}, '{1'b1, 4'h4, 1'b0}, '{1'b1, 4'hF, 1'b0}
    };
    rst = 1'b1;
    tck = 1'b0;
    tms = 1'b1;
    tdi = 1'b0;
    data_in = '0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_state", {252'b0, tap_state}, 256'hF);
    check("rst_ir", {251'b0, ir_out}, 256'h11);
    check("rst_tdo_en", {255'b0, tdo_en}, 256'h0);
    check("rst_tdo", {255'b0, tdo}, 256'h0);
    check("rst_dout", data_out, 256'h0);
    check("rst_upd", {255'b0, data_update}, 256'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Walk all sixteen states.
    for (int i = 0; i < 24; i++) begin
      tck_cycle(tbl[i].tms, 1'b0, s);
      check($sformatf("walk%0d_state", i), {252'b0, tap_state}, {252'b0, tbl[i].st});
      check($sformatf("walk%0d_en", i), {255'b0, tdo_en}, {255'b0, tbl[i].en});
    end
    check("walk_ir", {251'b0, ir_out}, 256'h11);
    check("walk_upd", upd_cnt, 0);
    check("walk_dout", data_out, 256'h0);

    // IDCODE read.
    tck_cycle(1'b0, 1'b0, s);
    tdi_bits = '0;
    scan_dr({224'b0, 32'h1000_0B5D}, 32, 32);
    check("id_upd", upd_cnt, 0);
    check("id_dout", data_out, 256'h0);

    // Full-length user data scan.
    load_ir(5'h12);
    for (int k = 0; k < 8; k++) data_in[k*32 +: 32] = $urandom;
    tdi_bits = {256'b0, {32{8'hA5}}};
    scan_dr(data_in, 256, 256);
    check("data_dout", data_out, {32{8'hA5}});
    check("data_upd", upd_cnt, 1);

    // Over-length scan interrupted by a pause.
    for (int k = 0; k < 8; k++) data_in[k*32 +: 32] = $urandom;
    for (int k = 0; k < 16; k++) tdi_bits[k*32 +: 32] = $urandom;
    goto_shdr();
    mdl = data_in;
    mdl_len = 256;
    vidx = 0;
    shift_bits(100, 1'b1);
    tck_cycle(1'b0, 1'b0, s);
    tck_cycle(1'b0, 1'b1, s);
    tck_cycle(1'b0, 1'b1, s);
    check("pause_state", {252'b0, tap_state}, 256'h3);
    tck_cycle(1'b1, 1'b1, s);
    tck_cycle(1'b0, 1'b1, s);
    check("resume_state", {252'b0, tap_state}, 256'h2);
    shift_bits(170, 1'b1);
    finish_upd();
    exp_dout = mdl;
    check("pass_dout", data_out, exp_dout);
    check("pass_upd", upd_cnt, 2);

    // Unknown instruction selects bypass: 1,0,1,1,0 in, 0,1,0,1,1 out.
    load_ir(5'h03);
    tdi_bits = {507'b0, 5'b01101};
    scan_dr(256'h0, 1, 5);
    check("byp_dout", data_out, exp_dout);
    check("byp_upd", upd_cnt, 2);

    // Five tms=1 edges from Shift-DR.
    goto_shdr();
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, s);
    check("tlr5_state", {252'b0, tap_state}, 256'hF);
    check("tlr5_ir", {251'b0, ir_out}, 256'h11);

    // Reset in the middle of a user data shift.
    tck_cycle(1'b0, 1'b0, s);
    load_ir(5'h12);
    for (int k = 0; k < 16; k++) tdi_bits[k*32 +: 32] = $urandom;
    goto_shdr();
    mdl = data_in;
    mdl_len = 256;
    vidx = 0;
    shift_bits(100, 1'b0);
    check("mid_state", {252'b0, tap_state}, 256'h2);
    check("mid_en", {255'b0, tdo_en}, 256'h1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_state", {252'b0, tap_state}, 256'hF);
    check("abort_ir", {251'b0, ir_out}, 256'h11);
    check("abort_dout", data_out, 256'h0);
    check("abort_en", {255'b0, tdo_en}, 256'h0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_upd", upd_cnt, 2);
    check("abort_state2", {252'b0, tap_state}, 256'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
